pkt_src_arbiter: RTL and testbench
==================================

PKT_SRC_ARBITER -- requirements
Module: pkt_src_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of packet requesters (2..8).
REQ-002 SHALL have parameter PKT_W, default 13, packet width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 4, max consecutive packets per grant (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  arbitration enable; 0 blocks new grants and ends the current grant.
REQ-007 SHALL have port req_valid  input  NUM_SRC  per-requester packet valid.
REQ-008 SHALL have port req_pkt  input  NUM_SRC x PKT_W  per-requester packet data.
REQ-009 SHALL have port req_ready  output  NUM_SRC  per-requester accept; at most one bit high.
REQ-010 SHALL have port src_valid  output  1  packet-valid strobe to the packet generator.
REQ-011 SHALL have port pkt_out  output  PKT_W  packet to the packet generator input.
REQ-012 SHALL have port grant_id  output  clog2(NUM_SRC)  current or most recent owner index.
REQ-013 SHALL have port busy  output  1  high while in state BUSY.

Function
REQ-014 SHALL implement FSM with states IDLE and BUSY.
REQ-015 IDLE: if en=1 and any req_valid=1, SHALL pick owner round-robin starting at (last_owner+1) mod NUM_SRC, load grant_id, clear burst_cnt, go BUSY next cycle; otherwise stay IDLE.
REQ-016 IDLE: req_ready SHALL be all zero (one-cycle arbitration bubble per grant).
REQ-017 BUSY: req_ready[grant_id] SHALL equal en, combinationally; all other bits 0.
REQ-018 Transfer SHALL occur on a cycle with req_valid[grant_id]=1 and req_ready[grant_id]=1.
REQ-019 On a transfer, next cycle SHALL have src_valid=1 and pkt_out=req_pkt[grant_id] (latency 1 cycle).
REQ-020 On a non-transfer cycle, next cycle SHALL have src_valid=0 and pkt_out=0.
REQ-021 burst_cnt SHALL increment by 1 per transfer; 4-bit, never wraps.
REQ-022 BUSY SHALL return to IDLE after the cycle in which: transfer with burst_cnt=MAX_BURST-1, or req_valid[grant_id]=0, or en=0.
REQ-023 On BUSY->IDLE, last_owner SHALL become grant_id; grant_id SHALL hold its value in IDLE.
REQ-024 Requesters not selected SHALL never be dropped: their req_valid is only observed, never consumed.
REQ-025 Deassertion of en mid-burst SHALL suppress transfer that same cycle (req_ready low) and end the grant.
REQ-026 With a single active requester, it SHALL be re-granted after each IDLE bubble (throughput MAX_BURST per MAX_BURST+1 cycles).

Reset
REQ-027 On rst_n=0, SHALL asynchronously force state IDLE, src_valid=0, pkt_out=0, grant_id=0, burst_cnt=0, last_owner=NUM_SRC-1, busy=0.
REQ-028 req_ready SHALL be 0 while rst_n=0; first grant after reset SHALL go to lowest active index.
REQ-029 Reset mid-burst SHALL discard the burst with no partial src_valid pulse after release.

Structure
REQ-030 Shared package pkt_pkg SHALL hold PKT_W default, packet typedef pkt_t, and arbiter state enum arb_state_e.
REQ-031 Round-robin selection SHALL be a sub-module rr_picker (inputs req vector, last index; outputs found, index), purely combinational.
REQ-032 Output register SHALL be a single flop stage; no FIFO.

Verification
REQ-033 Reset then req_valid=4'b0001, pkt 13'h0AA, en=1 -> busy at cycle 2, src_valid with pkt_out=13'h0AA at cycle 3, grant_id=0.
REQ-034 All four req_valid held, MAX_BURST=4 -> grants 0,1,2,3,0 in order, exactly 4 src_valid pulses per grant, one idle cycle between grants.
REQ-035 Owner 2 drops req_valid after 2 packets -> exactly 2 pulses, IDLE next, next grant to 3 if valid else wraps to 0.
REQ-036 en driven 0 mid-burst after 1 packet -> req_ready all 0 that cycle, no further src_valid, return to IDLE; en=1 re-grants next owner.
REQ-037 rst_n asserted mid-burst -> src_valid, pkt_out, busy zero immediately; after release first grant to index 0.
REQ-038 Assertion check all cycles: onehot0(req_ready), src_valid=0 implies pkt_out=0.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared types and defaults for the packet source arbiter.
package pkt_pkg;

    localparam int unsigned PKT_W_DEF = 13;

    typedef logic [PKT_W_DEF-1:0] pkt_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_picker #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W-1:0] w_cand;

    // Scan offsets 1..NUM_SRC from the last owner; the first hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_cand = IDX_W'((32'(i_last) + k) % NUM_SRC);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/pkt_src_arbiter.sv
// Round-robin arbiter feeding one packet generator from NUM_SRC requesters,
// with bounded bursts and a one-cycle arbitration bubble per grant.
module pkt_src_arbiter
    import pkt_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned PKT_W     = PKT_W_DEF,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IDX_W    = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_SRC-1:0]       req_valid,
    input  logic [NUM_SRC*PKT_W-1:0] req_pkt,
    output logic [NUM_SRC-1:0]       req_ready,
    output logic                     src_valid,
    output logic [PKT_W-1:0]         pkt_out,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy
);

    arb_state_e       r_state;
    arb_state_e       w_next_state;
    logic [IDX_W-1:0] r_grant_id;
    logic [IDX_W-1:0] r_last_owner;
    logic [3:0]       r_burst_cnt;
    logic             r_src_valid;
    logic [PKT_W-1:0] r_pkt_out;

    logic             w_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_owner_valid;
    logic             w_xfer;
    logic             w_burst_last;
    logic [PKT_W-1:0] w_sel_pkt;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_last  (r_last_owner),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    assign w_owner_valid = req_valid[r_grant_id];
    assign w_xfer        = (r_state == BUSY) && en && w_owner_valid;
    assign w_burst_last  = (r_burst_cnt == 4'(MAX_BURST - 1));

    // Select the current owner's packet data.
    always_comb begin
        w_sel_pkt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (r_grant_id == IDX_W'(i)) begin
                w_sel_pkt = req_pkt[i*PKT_W +: PKT_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: grant when anyone asks; end grant on burst limit, owner drop or disable.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (en && w_found) w_next_state = BUSY;
            BUSY: if (!en || !w_owner_valid || w_burst_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: only the owner sees ready, and only while enabled.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (r_state == BUSY) begin
            busy                  = 1'b1;
            req_ready[r_grant_id] = en;
        end
    end

    // Grant bookkeeping: owner load, burst counting, last owner on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id   <= '0;
            r_burst_cnt  <= '0;
            r_last_owner <= IDX_W'(NUM_SRC - 1);
        end else begin
            if (r_state == IDLE && w_next_state == BUSY) begin
                r_grant_id  <= w_pick_idx;
                r_burst_cnt <= '0;
            end else if (w_xfer && r_burst_cnt != 4'hF) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end
            if (r_state == BUSY && w_next_state == IDLE) begin
                r_last_owner <= r_grant_id;
            end
        end
    end

    // Single output stage: registered strobe, data zeroed when nothing moved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_valid <= 1'b0;
            r_pkt_out   <= '0;
        end else begin
            r_src_valid <= w_xfer;
            r_pkt_out   <= w_xfer ? w_sel_pkt : '0;
        end
    end

    assign src_valid = r_src_valid;
    assign pkt_out   = r_pkt_out;
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_pkt_src_arbiter.sv
// Scoreboard bench for pkt_src_arbiter: directed scenarios push cycle-exact
// expected packets; a negedge monitor pops and compares every src_valid pulse.
module tb_pkt_src_arbiter;

    localparam int NS = 4;
    localparam int PW = 13;
    localparam int MB = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              en    = 1'b0;
    logic [NS-1:0]     req_valid = '0;
    logic [NS*PW-1:0]  req_pkt;
    logic [NS-1:0]     req_ready;
    logic              src_valid;
    logic [PW-1:0]     pkt_out;
    logic [1:0]        grant_id;
    logic              busy;

    logic [PW-1:0] PK [NS] = '{13'h0AA, 13'h1B1, 13'h0C2, 13'h1D3};
    assign req_pkt = {PK[3], PK[2], PK[1], PK[0]};

    pkt_src_arbiter #(
        .NUM_SRC   (NS),
        .PKT_W     (PW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_pkt   (req_pkt),
        .req_ready (req_ready),
        .src_valid (src_valid),
        .pkt_out   (pkt_out),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            gid;
        logic [PW-1:0] pkt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int g);
        exp_t e;
        e.cyc = c;
        e.gid = g;
        e.pkt = PK[g];
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        chk("drain_empty", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
        repeat (3) tick();
        chk("idle_after", {31'b0, busy}, 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_src_valid", {31'b0, src_valid}, 0);
        chk("rst_pkt_out", pkt_out, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ready", req_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each pulse.
    always @(negedge clk) begin
        exp_t e;
        chk("onehot0_ready", {31'b0, $onehot0(req_ready)}, 1);
        if (src_valid !== 1'b1) begin
            chk("pkt_zero_when_idle", pkt_out, 0);
        end else if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got pkt 0x%0h gid %0d expected no pulse (cycle %0d)",
                     pkt_out, grant_id, cyc);
        end else begin
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_gid", grant_id, e.gid);
            chk("pulse_pkt", pkt_out, e.pkt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int T0;
        int ord[5] = '{0, 1, 2, 3, 0};
        #1;

        // Single requester: latency, then re-grant after one bubble.
        do_reset();
        T0 = cyc;
        req_valid = 4'b0001;
        en        = 1'b1;
        for (int j = 0; j < 4; j++) push(T0 + 2 + j, 0);
        for (int j = 0; j < 4; j++) push(T0 + 7 + j, 0);
        chk("t1_busy_c0", {31'b0, busy}, 0);
        tick();
        chk("t1_busy_c1", {31'b0, busy}, 1);
        chk("t1_gid", grant_id, 0);
        chk("t1_ready", req_ready, 4'b0001);
        repeat (9) tick();
        req_valid = '0;
        drain();

        // All four requesting: grants 0,1,2,3,0 with 4 packets each.
        do_reset();
        T0 = cyc;
        req_valid = 4'b1111;
        en        = 1'b1;
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 4; j++) push(T0 + 2 + 5*k + j, ord[k]);
        repeat (25) tick();
        req_valid = '0;
        drain();

        // Owner 2 drops after 2 packets; next grant 3, then wrap to 0.
        do_reset();
        T0 = cyc;
        req_valid = 4'b0100;
        en        = 1'b1;
        push(T0 + 2, 2);
        push(T0 + 3, 2);
        for (int j = 0; j < 4; j++) push(T0 + 6 + j, 3);
        for (int j = 0; j < 4; j++) push(T0 + 11 + j, 0);
        repeat (3) tick();
        req_valid = 4'b1001;
        tick();
        chk("t3_idle_after_drop", {31'b0, busy}, 0);
        repeat (10) tick();
        req_valid = '0;
        drain();

        // en drops after one packet; re-enable grants next owner.
        do_reset();
        T0 = cyc;
        req_valid = 4'b0011;
        en        = 1'b1;
        push(T0 + 2, 0);
        for (int j = 0; j < 4; j++) push(T0 + 7 + j, 1);
        repeat (2) tick();
        en = 1'b0;
        #1;
        chk("t4_ready_en0", req_ready, 0);
        tick();
        chk("t4_idle_en0", {31'b0, busy}, 0);
        repeat (2) tick();
        en = 1'b1;
        repeat (5) tick();
        req_valid = '0;
        drain();

        // Reset mid-burst: outputs clear at once, first grant after release is 0.
        do_reset();
        T0 = cyc;
        req_valid = 4'b1111;
        en        = 1'b1;
        push(T0 + 2, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_src_valid", {31'b0, src_valid}, 0);
        chk("t5_rst_pkt_out", pkt_out, 0);
        chk("t5_rst_busy", {31'b0, busy}, 0);
        chk("t5_rst_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) push(T0 + 6 + j, 0);
        tick();
        chk("t5_busy_after", {31'b0, busy}, 1);
        chk("t5_gid_after", grant_id, 0);
        repeat (4) tick();
        req_valid = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
